// File: rtl/ram_1p_arb.sv
// Two-host round-robin arbiter in front of a single-port SRAM.
// Routes the 1-cycle response back to the granted host.
module ram_1p_arb #(
  parameter int Width = 32,
  parameter int Depth = 128,
  parameter int CntW  = 16,
  localparam int Aw   = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             a_req_i,
  input  logic             a_we_i,
  input  logic [Aw-1:0]    a_addr_i,
  input  logic [Width-1:0] a_wdata_i,
  input  logic             b_req_i,
  input  logic             b_we_i,
  input  logic [Aw-1:0]    b_addr_i,
  input  logic [Width-1:0] b_wdata_i,
  output logic             a_gnt_o,
  output logic             b_gnt_o,
  output logic             a_rvalid_o,
  output logic             b_rvalid_o,
  output logic [Width-1:0] a_rdata_o,
  output logic [Width-1:0] b_rdata_o,
  output logic             ram_req_o,
  output logic             ram_write_o,
  output logic [Aw-1:0]    ram_addr_o,
  output logic [Width-1:0] ram_wdata_o,
  input  logic             ram_rvalid_i,
  input  logic [Width-1:0] ram_rdata_i,
  output logic [CntW-1:0]  conflict_cnt_o,
  output logic             err_o
);

  localparam logic [CntW-1:0] CntMax = '1;

  logic            prio_q;
  logic            pend_q;
  logic            owner_q;
  logic [CntW-1:0] conflict_q;
  logic            err_q;
  logic            a_gnt;
  logic            b_gnt;

  // prio_q: 0 prefers A, 1 prefers B
  assign a_gnt = a_req_i & (~b_req_i | ~prio_q);
  assign b_gnt = b_req_i & (~a_req_i | prio_q);

  assign a_gnt_o   = a_gnt;
  assign b_gnt_o   = b_gnt;
  assign ram_req_o = a_req_i | b_req_i;

  always_comb begin
    ram_write_o = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    unique case (1'b1)
      a_gnt: begin
        ram_write_o = a_we_i;
        ram_addr_o  = a_addr_i;
        ram_wdata_o = a_wdata_i;
      end
      b_gnt: begin
        ram_write_o = b_we_i;
        ram_addr_o  = b_addr_i;
        ram_wdata_o = b_wdata_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q     <= 1'b0;
      pend_q     <= 1'b0;
      owner_q    <= 1'b0;
      conflict_q <= '0;
      err_q      <= 1'b0;
    end else begin
      pend_q <= a_gnt | b_gnt;
      if (a_gnt) begin
        prio_q  <= 1'b1;
        owner_q <= 1'b0;
      end else if (b_gnt) begin
        prio_q  <= 1'b0;
        owner_q <= 1'b1;
      end
      if (a_req_i && b_req_i && conflict_q != CntMax)
        conflict_q <= conflict_q + CntW'(1);
      if (ram_rvalid_i && !pend_q)
        err_q <= 1'b1;
    end
  end

  assign a_rvalid_o     = ram_rvalid_i & pend_q & ~owner_q;
  assign b_rvalid_o     = ram_rvalid_i & pend_q & owner_q;
  assign a_rdata_o      = ram_rdata_i;
  assign b_rdata_o      = ram_rdata_i;
  assign conflict_cnt_o = conflict_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_ram_1p_arb.sv
// Bench for ram_1p_arb: behavioural RAM, arbitration model
// and a response scoreboard.
module tb_ram_1p_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [6:0]  a_addr = 0, b_addr = 0;
  logic [31:0] a_wdata = 0, b_wdata = 0;
  logic        a_gnt, b_gnt, a_rv, b_rv;
  logic [31:0] a_rdata, b_rdata;
  logic        ram_req, ram_write;
  logic [6:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_rv_q, frv = 1'b0, ram_rv;
  logic [31:0] ram_rdata;
  logic [15:0] cnt;
  logic        err;
  logic        g4a, g4b, r4a, r4b, q4, w4, e4;
  logic [31:0] d4a, d4b, wd4;
  logic [6:0]  ad4;
  logic [3:0]  cnt4;

  logic        pl = 1'b0;
  logic [6:0]  pl_addr = 0;
  logic [31:0] pl_data = 0;
  logic [31:0] mem [128];
  logic [31:0] exp_mem [128];

  typedef struct {
    logic        host;
    logic        we;
    logic [31:0] data;
  } sb_t;
  sb_t sb[$];

  logic        prio_m, err_m;
  logic [15:0] cnt_m;
  logic [3:0]  cnt4_m;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign ram_rv = ram_rv_q | frv;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) ram_rv_q <= 1'b0;
    else ram_rv_q <= ram_req;

  always @(posedge clk) begin
    if (pl) mem[pl_addr] <= pl_data;
    else if (ram_req && ram_write) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  ram_1p_arb dut (
    .clk_i(clk), .rst_ni(rst_n),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .a_gnt_o(a_gnt), .b_gnt_o(b_gnt),
    .a_rvalid_o(a_rv), .b_rvalid_o(b_rv),
    .a_rdata_o(a_rdata), .b_rdata_o(b_rdata),
    .ram_req_o(ram_req), .ram_write_o(ram_write),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
    .ram_rvalid_i(ram_rv), .ram_rdata_i(ram_rdata),
    .conflict_cnt_o(cnt), .err_o(err)
  );

  ram_1p_arb #(.CntW(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .a_gnt_o(g4a), .b_gnt_o(g4b),
    .a_rvalid_o(r4a), .b_rvalid_o(r4b),
    .a_rdata_o(d4a), .b_rdata_o(d4b),
    .ram_req_o(q4), .ram_write_o(w4),
    .ram_addr_o(ad4), .ram_wdata_o(wd4),
    .ram_rvalid_i(ram_rv), .ram_rdata_i(ram_rdata),
    .conflict_cnt_o(cnt4), .err_o(e4)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic ar, input logic aw,
                      input logic [6:0] aa, input logic [31:0] ad,
                      input logic br, input logic bw,
                      input logic [6:0] ba, input logic [31:0] bd,
                      input logic fr);
    logic ga, gb, has;
    logic [6:0] ea;
    sb_t e;
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    frv = fr;
    @(negedge clk);
    ga = ar & (~br | ~prio_m);
    gb = br & (~ar | prio_m);
    chk("a_gnt", a_gnt, ga);
    chk("b_gnt", b_gnt, gb);
    chk("ram_req", ram_req, ar | br);
    ea = ga ? aa : gb ? ba : 7'd0;
    chk("ram_addr", ram_addr, ea);
    chk("ram_write", ram_write, ga ? aw : gb ? bw : 1'b0);
    chk("ram_wdata", ram_wdata, ga ? ad : gb ? bd : 32'd0);
    has = sb.size() > 0;
    e = '{host: 1'b0, we: 1'b0, data: 32'd0};
    if (has) e = sb.pop_front();
    chk("a_rvalid", a_rv, has && !e.host);
    chk("b_rvalid", b_rv, has && e.host);
    if (has && !e.we)
      chk(e.host ? "b_rdata" : "a_rdata", e.host ? b_rdata : a_rdata, e.data);
    chk("err", err, err_m);
    chk("cnt", cnt, cnt_m);
    chk("cnt4", cnt4, cnt4_m);
    err_m = err_m | (fr & ~has);
    if (ar && br) begin
      if (cnt_m != 16'hffff) cnt_m++;
      if (cnt4_m != 4'hf) cnt4_m++;
    end
    if (ga | gb) begin
      sb.push_back('{host: gb, we: ga ? aw : bw, data: exp_mem[ea]});
      if (ga ? aw : bw) exp_mem[ea] = ga ? ad : bd;
      prio_m = ga;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_req = 0; b_req = 0; frv = 0;
    sb.delete();
    prio_m = 0; err_m = 0; cnt_m = 0; cnt4_m = 0;
    @(negedge clk);
    chk("rst_a_rvalid", a_rv, 0);
    chk("rst_b_rvalid", b_rv, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_gnt", {a_gnt, b_gnt, ram_req}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    prio_m = 0; err_m = 0; cnt_m = 0; cnt4_m = 0;
    pl = 1'b1;
    for (int i = 0; i < 128; i++) begin
      pl_addr = 7'(i);
      pl_data = (i == 5) ? 32'hdeadbeef : 32'(i) * 32'h01010101;
      exp_mem[i] = pl_data;
      @(posedge clk);
      #1;
    end
    pl = 1'b0;
    do_reset();

    step(1, 0, 5, 0, 0, 0, 0, 0, 0);
    idle();
    step(0, 0, 0, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++)
      step(1, 0, 7'(i), 0, 1, 0, 7'(i + 10), 0, 0);
    idle();
    chk("cnt6", cnt, 6);

    step(0, 0, 0, 0, 1, 1, 127, 32'h12345678, 0);
    step(1, 0, 127, 0, 0, 0, 0, 0, 0);
    idle();

    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    chk("err_set", err, 1);
    for (int i = 0; i < 4; i++)
      step(1, 0, 7'(i), 0, 1, 1, 7'(i + 40), $urandom, 0);
    idle();
    chk("err_sticky", err, 1);
    do_reset();

    for (int i = 0; i < 20; i++)
      step(1, 0, 7'(i), 0, 1, 0, 7'(i + 60), 0, 0);
    idle();
    chk("cnt4_sat", cnt4, 15);
    chk("cnt20", cnt, 20);

    step(1, 0, 9, 0, 0, 0, 0, 0, 0);
    do_reset();
    step(1, 0, 3, 0, 1, 0, 4, 0, 0);
    idle();

    for (int i = 0; i < 60; i++)
      step(1'($urandom), 1'($urandom), 7'($urandom), $urandom,
           1'($urandom), 1'($urandom), 7'($urandom), $urandom, 0);
    idle();
    chk("sb_drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_1p_arb.md
# ram_1p_arb

Two-host round-robin arbiter in front of a single-port synchronous SRAM (`ram_1p`, Width/Depth matching). It sits between two requesters (e.g. core instruction-fetch port A and debug/DMA port B) and the one RAM port. Each cycle it grants at most one request and returns the RAM's 1-cycle-latency read response to the host that issued it. It also keeps a saturating conflict counter and a sticky protocol-error flag.

## Interface
- `Width`, 32, data width; must equal the attached RAM's Width
- `Depth`, 128, RAM depth in words
- `Aw`, $clog2(Depth), address width; derived, not overridden
- `CntW`, 16, conflict counter width

- `clk_i`  in  1  clock; one clock domain
- `rst_ni`  in  1  asynchronous active-low reset
- `a_req_i`, `b_req_i`  in  1  host request (A / B)
- `a_we_i`, `b_we_i`  in  1  1 = write, 0 = read
- `a_addr_i`, `b_addr_i`  in  Aw  word address
- `a_wdata_i`, `b_wdata_i`  in  Width  write data
- `a_gnt_o`, `b_gnt_o`  out  1  request accepted this cycle
- `a_rvalid_o`, `b_rvalid_o`  out  1  response for this host's previously granted request
- `a_rdata_o`, `b_rdata_o`  out  Width  read data; meaningful only with rvalid
- `ram_req_o`  out  1  to RAM `req_i`
- `ram_write_o`  out  1  to RAM `write_i`
- `ram_addr_o`  out  Aw  to RAM `addr_i`
- `ram_wdata_o`  out  Width  to RAM `wdata_i`
- `ram_rvalid_i`  in  1  from RAM `rvalid_o`
- `ram_rdata_i`  in  Width  from RAM `rdata_o`
- `conflict_cnt_o`  out  CntW  cycles where both hosts requested; saturating
- `err_o`  out  1  sticky: `ram_rvalid_i` seen with no pending grant

## Operation
- State: `prio_q` (0 = A preferred, 1 = B preferred), `pend_q`, `owner_q` (0 = A, 1 = B), `conflict_q`, `err_q`.
- Grant is combinational in the same cycle as the request:
  - Only A requests → A granted.
  - Only B requests → B granted.
  - Both request → host selected by `prio_q`.
  - At most one `*_gnt_o` is high in any cycle.
- RAM mux: `ram_req_o` = a_req | b_req. `ram_write_o`, `ram_addr_o` and `ram_wdata_o` come from the granted host; all are 0 when neither host requests.
- Round-robin: on any grant to host X, `prio_q` ← the other host. No grant → `prio_q` holds.
- Response tracking: each cycle `pend_q` ← (any grant) and `owner_q` ← granted host. If there is no grant, `owner_q` holds.
- Response routing:
  - `x_rvalid_o` = ram_rvalid_i & pend_q & (owner_q == x).
  - `a_rdata_o` = `b_rdata_o` = ram_rdata_i (broadcast).
  - Writes also produce an rvalid, since the RAM acknowledges every request. Hosts treat it as a write ack; rdata is don't-care.
- Error: if ram_rvalid_i & !pend_q → `err_q` ← 1. It stays 1 until reset. No host rvalid is raised for that response.
- Conflict count: if a_req_i & b_req_i → `conflict_q` +1. It saturates at 2^CntW−1 and does not wrap.
- Hosts hold req/we/addr/wdata stable until gnt. The arbiter has no queueing; an ungranted request is simply re-evaluated next cycle.

## Timing
- Reset (async, rst_ni low): `prio_q`=0, `pend_q`=0, `owner_q`=0, `conflict_q`=0, `err_q`=0.
- Outputs while in reset:
  - `a_rvalid_o`, `b_rvalid_o`, `err_o`, `conflict_cnt_o` = 0.
  - Grants and `ram_*` outputs follow the reset-state arbitration rule. Hosts hold req low during reset, so all of these are 0.
- Grant latency: 0 cycles (combinational from req). Grant→rvalid latency: exactly 1 cycle.
- Back-to-back: a grant in every cycle is legal. Response N appears in the same cycle as grant N+1, and `owner_q` selects the correct host without a bubble.
- Reset mid-operation: a pending response is dropped (`pend_q` cleared). A RAM rvalid arriving in the first cycle after reset release sets `err_o`. The RAM resets its rvalid on the same reset, so in a correct system this does not occur.
- Simultaneous events: a counter increment and a grant in the same cycle both take effect. A grant and a routed response in the same cycle are independent.

## Test plan
- Reset, then A alone reads addr 5 (RAM preloaded 0xDEADBEEF) → `a_gnt_o`=1 in cycle 0; `a_rvalid_o`=1 with `a_rdata_o`=0xDEADBEEF in cycle 1; `b_rvalid_o`=0 throughout.
- Both hosts request continuously for 6 cycles → grants alternate A,B,A,B,A,B; `conflict_cnt_o`=6; each rvalid goes to the host granted in the previous cycle.
- B writes 0x12345678 to addr 127, then A reads addr 127 in the next cycle → B gets a write ack (`b_rvalid_o`=1); one cycle later `a_rdata_o`=0x12345678.
- Force `ram_rvalid_i`=1 with no prior grant → `err_o`=1; it stays 1 through later traffic and clears only on reset.
- With CntW=4, drive 20 conflict cycles → `conflict_cnt_o` stops at 15 and does not wrap.
- Assert rst_ni low in the cycle after a grant to A → `a_rvalid_o` stays 0; `prio_q` returns to A-preferred, so the first conflict after reset grants A.
